vga_scan_timing: RTL

- Generates 640x480@60 Hz VGA raster timing for the sprite drawing stages.
- Produces DrawX/DrawY, blank, hs and vs to the sprite/palette renderers and the monitor.
- Produces line_end, frame_end and frame_count for per-frame game and animation updates.
- Sits directly upstream of every sprite renderer and runs on vga_clk.

---
 rtl/vga_scan_timing_if.sv | 37 +++
 rtl/vga_scan_timing.sv | 123 ++++++++++++
 2 files changed

// File: rtl/vga_scan_timing_if.sv
// ---------------------------------------------------------------------------
// vga_scan_timing_if
//   Raster timing bundle between the VGA scan generator and its consumers
//   (sprite/palette renderers, monitor output stage).
//
//   pix_ce       consumer -> generator   pixel advance enable
//   DrawX/DrawY  generator -> consumer   current raster position
//   blank        generator -> consumer   1 = visible region
//   hs, vs       generator -> consumer   active-low syncs
//   line_end     generator -> consumer   pulse on last pixel of a line
//   frame_end    generator -> consumer   pulse on last pixel of a frame
//   frame_count  generator -> consumer   completed-frame counter
//
//   master: the timing generator.  slave: whoever supplies pix_ce and
//   consumes the raster position.
// ---------------------------------------------------------------------------
interface vga_scan_timing_if;
    logic       pix_ce;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       line_end;
    logic       frame_end;
    logic [7:0] frame_count;

    modport master (
        input  pix_ce,
        output DrawX, DrawY, blank, hs, vs, line_end, frame_end, frame_count
    );

    modport slave (
        output pix_ce,
        input  DrawX, DrawY, blank, hs, vs, line_end, frame_end, frame_count
    );
endinterface

// File: rtl/vga_scan_timing.sv
// ---------------------------------------------------------------------------
// vga_scan_timing
//   640x480@60 Hz raster timing generator (porches/sync widths are
//   parameters).  Every output is a register; blank/hs/vs/pulses are
//   computed from the next-state counter values so they always describe
//   the (DrawX, DrawY) presented in the same cycle.
//
//   vga_clk   pixel clock
//   reset_n   asynchronous active-low reset
//   vga       master side of vga_scan_timing_if (pix_ce in, timing out)
// ---------------------------------------------------------------------------
module vga_scan_timing #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic                 vga_clk,
    input  logic                 reset_n,
    vga_scan_timing_if.master    vga
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEGIN = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] draw_x;
    logic [9:0] draw_y;
    logic       blank_q;
    logic       hs_q;
    logic       vs_q;
    logic       line_end_q;
    logic       frame_end_q;
    logic [7:0] frame_count_q;

    logic       x_last;
    logic       y_last;
    logic [9:0] x_nxt;
    logic [9:0] y_nxt;
    logic       blank_nxt;
    logic       hs_nxt;
    logic       vs_nxt;
    logic       line_end_nxt;
    logic       frame_end_nxt;
    logic [7:0] frame_count_nxt;

    // Next raster position.  The ">=" compares make the counters fall back
    // to zero even if a value past the totals were ever forced in.
    always_comb begin
        x_last = (draw_x >= H_LAST);
        y_last = (draw_y >= V_LAST);

        x_nxt = x_last ? 10'd0 : draw_x + 10'd1;
        y_nxt = draw_y;
        if (x_last) begin
            y_nxt = y_last ? 10'd0 : draw_y + 10'd1;
        end

        frame_count_nxt = frame_count_q;
        if (x_last && y_last) begin
            frame_count_nxt = frame_count_q + 8'd1;
        end
    end

    // Decode on the next position so the registered flags line up with the
    // registered counters (no one-cycle lag for downstream sprite stages).
    always_comb begin
        blank_nxt     = (x_nxt < H_VIS) && (y_nxt < V_VIS);
        hs_nxt        = !((x_nxt >= HS_BEGIN) && (x_nxt < HS_END));
        vs_nxt        = !((y_nxt >= VS_BEGIN) && (y_nxt < VS_END));
        line_end_nxt  = (x_nxt == H_LAST);
        frame_end_nxt = line_end_nxt && (y_nxt == V_LAST);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            draw_x        <= 10'd0;
            draw_y        <= 10'd0;
            blank_q       <= 1'b1;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            line_end_q    <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_count_q <= 8'd0;
        end else if (vga.pix_ce) begin
            draw_x        <= x_nxt;
            draw_y        <= y_nxt;
            blank_q       <= blank_nxt;
            hs_q          <= hs_nxt;
            vs_q          <= vs_nxt;
            line_end_q    <= line_end_nxt;
            frame_end_q   <= frame_end_nxt;
            frame_count_q <= frame_count_nxt;
        end else begin
            // Stalled cycle: position and syncs hold, but the pulses must
            // not be seen twice by per-line/per-frame consumers.
            line_end_q    <= 1'b0;
            frame_end_q   <= 1'b0;
        end
    end

    assign vga.DrawX       = draw_x;
    assign vga.DrawY       = draw_y;
    assign vga.blank       = blank_q;
    assign vga.hs          = hs_q;
    assign vga.vs          = vs_q;
    assign vga.line_end    = line_end_q;
    assign vga.frame_end   = frame_end_q;
    assign vga.frame_count = frame_count_q;

endmodule
